// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner
//   Purpose : converts a binary value to BCD with a sequential double-dabble
//             FSM and time-multiplexes the digits onto a nibble bus that feeds
//             a registered 7-segment decoder.
//   Latency : i_Load edge to committed display data is DATA_WIDTH+1 clocks;
//             o_Binary_Num is registered (1 clk), o_Digit_Sel lags it by 1 clk.
//   Backpressure: none; i_Load is dropped while o_Busy is high (no queueing).
// Ports
//   i_Clk        system clock, rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_Value      unsigned value to display
//   i_Load       1-cycle strobe, samples i_Value and starts a conversion
//   o_Busy       conversion in progress
//   o_Overflow   last committed value does not fit in NUM_DIGITS digits
//   o_Binary_Num BCD digit or 4'hF (blank) for the decoder
//   o_Digit_Sel  one-hot active-high digit enable, aligned to decoder output
module seg_digit_scanner #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_DIGITS    = 3,
  parameter int SCAN_DIV      = 25000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [DATA_WIDTH-1:0] i_Value,
  input  logic                  i_Load,
  output logic                  o_Busy,
  output logic                  o_Overflow,
  output logic [3:0]            o_Binary_Num,
  output logic [NUM_DIGITS-1:0] o_Digit_Sel
);

  // Enough BCD digits for any DATA_WIDTH-bit value plus one spare, and never
  // fewer than the displayed digits so the display slice always exists.
  localparam int BCD_MIN  = (DATA_WIDTH * 301) / 1000 + 2;
  localparam int BCD_DIGS = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int BCD_W    = 4 * BCD_DIGS;
  localparam int PS_W     = $clog2(SCAN_DIV);
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W    = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    val_q;
  logic [BCD_W-1:0]         bcd_q;
  logic [BCD_W-1:0]         bcd_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [4*NUM_DIGITS-1:0]  disp_q;
  logic [4*NUM_DIGITS-1:0]  disp_d;
  logic                     ovf_d;
  logic [PS_W-1:0]          ps_q;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         idx_dly_q;
  logic [3:0]               cur_dig;
  logic [NUM_DIGITS-1:0]    sel_d;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the
  // next value bit. The scratch has a spare digit, so the shift never loses data.
  always_comb begin
    logic [BCD_W-1:0] adj;
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = (adj << 1) | BCD_W'(val_q[DATA_WIDTH-1]);
  end

  // Display image built from the finished scratch: overflow blanks every
  // digit; otherwise leading zeros above the top nonzero digit are blanked.
  always_comb begin
    logic lead;
    ovf_d  = 1'b0;
    lead   = 1'b1;
    for (int i = NUM_DIGITS; i < BCD_DIGS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
    end
    disp_d = bcd_q[4*NUM_DIGITS-1:0];
    if (ovf_d) begin
      disp_d = '1;
    end else if (BLANK_LEADING != 0) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (bcd_q[4*i +: 4] != 4'd0) lead = 1'b0;
        else if (lead)               disp_d[4*i +: 4] = 4'hF;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      val_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '1;
      o_Busy     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Load) begin
            val_q   <= i_Value;
            bcd_q   <= '0;
            cnt_q   <= '0;
            o_Busy  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q <= bcd_d;
          val_q <= val_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q     <= disp_d;
          o_Overflow <= ovf_d;
          o_Busy     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Digit mux and one-hot enable for the delayed index.
  always_comb begin
    cur_dig = 4'hF;
    sel_d   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i))     cur_dig  = disp_q[4*i +: 4];
      if (idx_dly_q == IDX_W'(i)) sel_d[i] = 1'b1;
    end
  end

  // Scan runs free of the FSM; the enable trails the nibble by one clock so
  // it lines up with the decoder's registered segments.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ps_q         <= '0;
      idx_q        <= '0;
      idx_dly_q    <= '0;
      o_Binary_Num <= 4'hF;
      o_Digit_Sel  <= '0;
    end else begin
      if (ps_q == PS_W'(SCAN_DIV - 1)) begin
        ps_q  <= '0;
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        ps_q <= ps_q + PS_W'(1);
      end
      idx_dly_q    <= idx_q;
      o_Binary_Num <= cur_dig;
      o_Digit_Sel  <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: two instances share stimulus, one with three
// blanked digits and one with two unblanked digits (the only way an 8-bit
// value can overflow). Expected digits come from decimal arithmetic.
module tb_seg_digit_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] val = 8'd0;
  logic       busy3, ovf3, busy2, ovf2;
  logic [3:0] bin3, bin2;
  logic [2:0] sel3;
  logic [1:0] sel2;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  seg_digit_scanner #(.DATA_WIDTH(8), .NUM_DIGITS(3), .SCAN_DIV(4), .BLANK_LEADING(1)) dut3 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Value(val), .i_Load(load),
    .o_Busy(busy3), .o_Overflow(ovf3), .o_Binary_Num(bin3), .o_Digit_Sel(sel3));

  seg_digit_scanner #(.DATA_WIDTH(8), .NUM_DIGITS(2), .SCAN_DIV(4), .BLANK_LEADING(0)) dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Value(val), .i_Load(load),
    .o_Busy(busy2), .o_Overflow(ovf2), .o_Binary_Num(bin2), .o_Digit_Sel(sel2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int p10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Digit k as the display should show it, from plain decimal arithmetic.
  function automatic int exp_dig(input int v, input int nd, input bit blank, input int k);
    if (v >= p10(nd)) return 15;
    if (blank && k > 0 && v < p10(k)) return 15;
    return (v / p10(k)) % 10;
  endfunction

  // Issue a load and measure how long o_Busy stays high; optionally fire a
  // second load on busy cycle second_at, which must be ignored.
  task automatic do_load(input int v, input int second_at, input int v2);
    int nb3 = 0;
    int nb2 = 0;
    val  = 8'(v);
    load = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (busy3) nb3++;
      if (busy2) nb2++;
      load = (c == second_at);
      if (c == second_at) val = 8'(v2);
      if (!busy3 && !busy2) break;
      tick();
    end
    load = 1'b0;
    chk($sformatf("busy_len3 v=%0d", v), nb3, 9);
    chk($sformatf("busy_len2 v=%0d", v), nb2, 9);
  endtask

  // Reconstruct each instance's display from the scan: the nibble seen one
  // cycle before a digit's enable is that digit's value.
  task automatic read_check(input int v, input bit all_blank);
    logic [3:0] g3 [3];
    logic [3:0] g2 [2];
    bit         s3 [3];
    bit         s2 [2];
    logic [3:0] p3, p2;
    for (int k = 0; k < 3; k++) begin g3[k] = 4'h0; s3[k] = 1'b0; end
    for (int k = 0; k < 2; k++) begin g2[k] = 4'h0; s2[k] = 1'b0; end
    tick();
    p3 = bin3;
    p2 = bin2;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int k = 0; k < 3; k++) if (sel3[k]) begin g3[k] = p3; s3[k] = 1'b1; end
      for (int k = 0; k < 2; k++) if (sel2[k]) begin g2[k] = p2; s2[k] = 1'b1; end
      chk("sel3_onehot", 32'($onehot(sel3)), 1);
      chk("sel2_onehot", 32'($onehot(sel2)), 1);
      p3 = bin3;
      p2 = bin2;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("dig3[%0d] v=%0d", k, v), s3[k] ? 32'(g3[k]) : 32'hDEAD,
          all_blank ? 15 : exp_dig(v, 3, 1'b1, k));
    for (int k = 0; k < 2; k++)
      chk($sformatf("dig2[%0d] v=%0d", k, v), s2[k] ? 32'(g2[k]) : 32'hDEAD,
          all_blank ? 15 : exp_dig(v, 2, 1'b0, k));
    chk($sformatf("ovf3 v=%0d", v), ovf3, (!all_blank && v >= 1000) ? 1 : 0);
    chk($sformatf("ovf2 v=%0d", v), ovf2, (!all_blank && v >= 100) ? 1 : 0);
  endtask

  initial begin
    int nb;
    int v;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin3", bin3, 4'hF);
    chk("rst_bin2", bin2, 4'hF);
    chk("rst_busy3", busy3, 0);
    chk("rst_ovf3", ovf3, 0);
    chk("rst_sel3", sel3, 0);
    chk("rst_sel2", sel2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_sel3", sel3, 0);

    // Scan sequence: index after edge m is (m/4) mod N; the enable shows the
    // index from two edges earlier, so it trails the nibble by one clock.
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("scan_sel3 n=%0d", n), sel3, 1 << (((n < 2) ? 0 : (n - 2) / 4) % 3));
      chk($sformatf("scan_sel2 n=%0d", n), sel2, 1 << (((n < 2) ? 0 : (n - 2) / 4) % 2));
      chk($sformatf("scan_bin3 n=%0d", n), bin3, 4'hF);
    end

    // Directed values
    do_load(173, 0, 0); read_check(173, 1'b0);
    do_load(7, 0, 0);   read_check(7, 1'b0);
    do_load(0, 0, 0);   read_check(0, 1'b0);
    do_load(200, 0, 0); read_check(200, 1'b0);
    do_load(99, 0, 0);  read_check(99, 1'b0);

    // Load during busy is dropped
    do_load(255, 3, 12); read_check(255, 1'b0);

    // Random values
    for (int r = 0; r < 8; r++) begin
      v = int'($urandom_range(0, 255));
      do_load(v, 0, 0);
      read_check(v, 1'b0);
    end

    // Reset in the middle of a conversion
    val  = 8'd173;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_busy3", busy3, 0);
    chk("midrst_bin3", bin3, 4'hF);
    chk("midrst_sel3", sel3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (busy3 || busy2) nb++;
    end
    chk("midrst_busy_after", nb, 0);
    read_check(173, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
